multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  A/B are sampled as an operation this cycle.
REQ-005 A  input  32  IEEE-754 binary32 operand.
REQ-006 B  input  32  IEEE-754 binary32 operand.
REQ-007 S  output  32  binary32 product A*B, registered.
REQ-008 out_valid  output  1  S holds the result of the operation issued 2 cycles earlier.
REQ-009 flags  output  4  {invalid, overflow, underflow, inexact}; present only with MULT_FLAGS_EN.

Function
REQ-010 The block SHALL be a 2-stage pipeline with fixed latency 2, accept one operation per cycle, and have no backpressure.
- Stage 1: sign XOR, exponent sum, 24x24 mantissa product, special-case classification.
- Stage 2: normalize, round, pack.
REQ-011 out_valid SHALL equal in_valid delayed by 2 cycles.
- S SHALL update only when the stage-2 valid is 1; otherwise it holds its value.
REQ-012 Result sign SHALL be sign(A) XOR sign(B) for all non-NaN results, including zero and infinity.
REQ-013 Biased exponent SHALL be eA+eB-127, +1 when the mantissa product is >= 2.0.
REQ-014 Rounding SHALL be round-to-nearest-even using guard, round and sticky bits.
- A rounding carry SHALL renormalize and increment the exponent.
REQ-015 Subnormal inputs (exp=0, frac!=0) SHALL be treated as signed zero (flush-to-zero).
REQ-016 After rounding, a result below 2^-126 SHALL be signed zero and set underflow.
REQ-017 After rounding, a biased exponent >= 255 SHALL give signed infinity and set overflow and inexact.
REQ-018 Special operands SHALL produce:
- Any NaN operand, or inf*0: canonical quiet NaN 32'h7FC00000; inf*0 also sets invalid.
- inf*finite-nonzero or inf*inf: signed infinity.
- 0*finite: signed zero.
REQ-019 Any discarded nonzero fraction bit SHALL set inexact.
REQ-020 flags SHALL be registered alongside S with the same latency.

Reset
REQ-021 While rst=1 at a clock edge:
- S<=32'h0, out_valid<=0, flags<=0.
- All pipeline valid bits SHALL clear.
REQ-022 Operations in flight when rst asserts SHALL be discarded and never produce out_valid.
REQ-023 in_valid asserted during a reset cycle SHALL be ignored.
- The first result SHALL appear 2 cycles after the first post-reset in_valid.

Configuration
REQ-024 With macro MULT_FLAGS_EN defined, the flags port and its logic SHALL exist as in REQ-009/016/017/018/019/020.
REQ-025 Without MULT_FLAGS_EN, the flags port SHALL be absent and S/out_valid behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL cover these cases, each issued with in_valid=1 and checked two cycles later:
- A=C1CC0000 (-25.5), B=C1CAC000 -> S=44219100 (646.265625), inexact=0.
- A=40BC0000, B=3F180000 -> S=405F4000.
- A=BE480000, B=3E380000 -> S=BD0FC000 (negative sign).
- A=7F800000, B=00000000 -> S=7FC00000, invalid=1.
- A=FF800000, B=40166666 -> S=FF800000.
- A=FF800000, B=FF800000 -> S=7F800000.
- A=7FFFFFFF, B=C1740000 -> S=7FC00000.
- A=7F000000, B=40000000 -> S=7F800000, overflow=1.
REQ-027 Back-to-back issue of all cases in consecutive cycles SHALL return results in order with out_valid high for the same count.
- Asserting rst mid-stream SHALL suppress all pending results.

Source files
------------

// File: rtl/multiplier_if.sv
// Operand/result bundle for the binary32 multiplier.
// The flags field exists only when MULT_FLAGS_EN is defined.
interface multiplier_if;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] S;
    logic        out_valid;
`ifdef MULT_FLAGS_EN
    logic [3:0]  flags;

    modport master (output in_valid, A, B, input S, out_valid, flags);
    modport slave  (input in_valid, A, B, output S, out_valid, flags);
`else
    modport master (output in_valid, A, B, input S, out_valid);
    modport slave  (input in_valid, A, B, output S, out_valid);
`endif
endinterface

// File: rtl/multiplier.sv
// Two-stage IEEE-754 binary32 multiplier, round-to-nearest-even, subnormals flushed to zero.
// Define MULT_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags output.
module multiplier (
    input  logic         clk,
    input  logic         rst,
    multiplier_if.slave  bus
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        aSign, bSign;
    logic [7:0]  aExp, bExp;
    logic [22:0] aFrac, bFrac;
    logic        aNan, bNan, aInf, bInf, aZero, bZero;

    logic               sign1_d, nan1_d, inf1_d, zero1_d;
    logic signed [9:0]  exp1_d;
    logic [47:0]        prod1_d;

    logic               v1_q, sign1_q, nan1_q, inf1_q, zero1_q;
    logic signed [9:0]  exp1_q;
    logic [47:0]        prod1_q;

    logic [31:0] S_d, S_q;
    logic        outValid_q;

    assign aSign = bus.A[31];
    assign aExp  = bus.A[30:23];
    assign aFrac = bus.A[22:0];
    assign bSign = bus.B[31];
    assign bExp  = bus.B[30:23];
    assign bFrac = bus.B[22:0];

    // Exponent 0 covers both true zero and flushed subnormals.
    assign aNan  = (aExp == 8'hFF) && (aFrac != 23'd0);
    assign bNan  = (bExp == 8'hFF) && (bFrac != 23'd0);
    assign aInf  = (aExp == 8'hFF) && (aFrac == 23'd0);
    assign bInf  = (bExp == 8'hFF) && (bFrac == 23'd0);
    assign aZero = (aExp == 8'h00);
    assign bZero = (bExp == 8'h00);

    always_comb begin
        sign1_d = aSign ^ bSign;
        exp1_d  = $signed({2'b00, aExp}) + $signed({2'b00, bExp}) - 10'sd127;
        prod1_d = {1'b1, aFrac} * {1'b1, bFrac};
        nan1_d  = aNan || bNan || (aInf && bZero) || (bInf && aZero);
        inf1_d  = !nan1_d && (aInf || bInf);
        zero1_d = !nan1_d && !inf1_d && (aZero || bZero);
    end

    logic [22:0]       mant, mantOut;
    logic              guard, rnd, sticky, roundUp;
    logic [24:0]       mantRnd;
    logic signed [9:0] expN, expR;
    logic              finite, ovf, unf;

    // Product lies in [1,4); bit 47 selects which alignment feeds the 23-bit fraction.
    always_comb begin
        if (prod1_q[47]) begin
            mant   = prod1_q[46:24];
            guard  = prod1_q[23];
            rnd    = prod1_q[22];
            sticky = |prod1_q[21:0];
            expN   = exp1_q + 10'sd1;
        end else begin
            mant   = prod1_q[45:23];
            guard  = prod1_q[22];
            rnd    = prod1_q[21];
            sticky = |prod1_q[20:0];
            expN   = exp1_q;
        end
        roundUp = guard && (rnd || sticky || mant[0]);
        mantRnd = {2'b01, mant} + {24'd0, roundUp};
        expR    = mantRnd[24] ? expN + 10'sd1 : expN;
        mantOut = mantRnd[24] ? mantRnd[23:1] : mantRnd[22:0];
        finite  = !nan1_q && !inf1_q && !zero1_q;
        ovf     = finite && (expR >= 10'sd255);
        unf     = finite && (expR <= 10'sd0);

        if (nan1_q)
            S_d = QNAN;
        else if (inf1_q || ovf)
            S_d = {sign1_q, 8'hFF, 23'd0};
        else if (zero1_q || unf)
            S_d = {sign1_q, 31'd0};
        else
            S_d = {sign1_q, expR[7:0], mantOut};
    end

`ifdef MULT_FLAGS_EN
    logic       invalid1_d, invalid1_q;
    logic [3:0] flags_d, flags_q;

    assign invalid1_d = (aInf && bZero && !bNan) || (bInf && aZero && !aNan);

    // A flushed-to-zero result discards every fraction bit, so it is inexact too.
    always_comb begin
        if (nan1_q)
            flags_d = {invalid1_q, 3'b000};
        else if (inf1_q || zero1_q)
            flags_d = 4'b0000;
        else if (ovf)
            flags_d = 4'b0101;
        else if (unf)
            flags_d = 4'b0011;
        else
            flags_d = {3'b000, guard | rnd | sticky};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'd0;
        end else begin
            if (bus.in_valid)
                invalid1_q <= invalid1_d;
            if (v1_q)
                flags_q <= flags_d;
        end
    end

    assign bus.flags = flags_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            outValid_q <= 1'b0;
            S_q        <= 32'h0;
        end else begin
            v1_q       <= bus.in_valid;
            outValid_q <= v1_q;
            if (bus.in_valid) begin
                sign1_q <= sign1_d;
                exp1_q  <= exp1_d;
                prod1_q <= prod1_d;
                nan1_q  <= nan1_d;
                inf1_q  <= inf1_d;
                zero1_q <= zero1_d;
            end
            if (v1_q)
                S_q <= S_d;
        end
    end

    assign bus.S         = S_q;
    assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the binary32 multiplier; checks flags when MULT_FLAGS_EN is defined.
module tb_multiplier;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    multiplier_if bus ();

    multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int N = 15;

    // Operand pairs with hand-computed products and {invalid, overflow, underflow, inexact}.
    logic [31:0] tA [N] = '{32'hC1CC0000, 32'h40BC0000, 32'hBE480000, 32'h3F800001, 32'h3FFFFFFF,
                            32'h3F800001, 32'h7F800000, 32'hFF800000, 32'hFF800000, 32'h7FFFFFFF,
                            32'h00000000, 32'h00000001, 32'h7F000000, 32'h00800000, 32'h80800000};
    logic [31:0] tB [N] = '{32'hC1CAC000, 32'h3F180000, 32'h3E380000, 32'h3F800001, 32'h3FFFFFFF,
                            32'h3FC00000, 32'h00000000, 32'h40166666, 32'hFF800000, 32'hC1740000,
                            32'hC0000000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000};
    logic [31:0] tS [N] = '{32'h44219100, 32'h405F4000, 32'hBD0FC000, 32'h3F800002, 32'h407FFFFE,
                            32'h3FC00002, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h7FC00000,
                            32'h80000000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h80000000};
    logic [3:0]  tF [N] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1,
                            4'h1, 4'h8, 4'h0, 4'h0, 4'h0,
                            4'h0, 4'h0, 4'h5, 4'h3, 4'h3};

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.A        = 32'h3F800000;
        bus.B        = 32'h40000000;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.S !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_S got %h expected 00000000", bus.S);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid got %b expected 0", bus.out_valid);
        end
`ifdef MULT_FLAGS_EN
        vectors++;
        if (bus.flags !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got %h expected 0", bus.flags);
        end
`endif
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ignored_in_valid got out_valid %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_arith();
        for (int i = 0; i < 6; i++) begin
            issue(tA[i], tB[i]);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.S !== tS[i]) begin
                miscompares++;
                $display("[TB] FAIL arith_%0d got S=%h ov=%b expected S=%h ov=1", i, bus.S, bus.out_valid, tS[i]);
            end
`ifdef MULT_FLAGS_EN
            vectors++;
            if (bus.flags !== tF[i]) begin
                miscompares++;
                $display("[TB] FAIL arith_flags_%0d got %h expected %h", i, bus.flags, tF[i]);
            end
`endif
        end
    endtask

    task automatic test_specials();
        for (int i = 6; i < 12; i++) begin
            issue(tA[i], tB[i]);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.S !== tS[i]) begin
                miscompares++;
                $display("[TB] FAIL special_%0d got S=%h ov=%b expected S=%h ov=1", i, bus.S, bus.out_valid, tS[i]);
            end
`ifdef MULT_FLAGS_EN
            vectors++;
            if (bus.flags !== tF[i]) begin
                miscompares++;
                $display("[TB] FAIL special_flags_%0d got %h expected %h", i, bus.flags, tF[i]);
            end
`endif
        end
    endtask

    task automatic test_range();
        for (int i = 12; i < N; i++) begin
            issue(tA[i], tB[i]);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.S !== tS[i]) begin
                miscompares++;
                $display("[TB] FAIL range_%0d got S=%h ov=%b expected S=%h ov=1", i, bus.S, bus.out_valid, tS[i]);
            end
`ifdef MULT_FLAGS_EN
            vectors++;
            if (bus.flags !== tF[i]) begin
                miscompares++;
                $display("[TB] FAIL range_flags_%0d got %h expected %h", i, bus.flags, tF[i]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int highCount = 0;
        for (int j = 0; j < N + 5; j++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1)
                highCount++;
            if (j >= 2 && j - 2 < N) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.S !== tS[j-2]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_%0d got S=%h ov=%b expected S=%h ov=1", j - 2, bus.S, bus.out_valid, tS[j-2]);
                end
            end
            if (j < N) begin
                bus.A        = tA[j];
                bus.B        = tB[j];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        vectors++;
        if (highCount != N) begin
            miscompares++;
            $display("[TB] FAIL b2b_count got %0d expected %0d", highCount, N);
        end
    endtask

    task automatic test_mid_reset();
        int leaks = 0;
        @(negedge clk);
        bus.A        = tA[0];
        bus.B        = tB[0];
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.A        = tA[1];
        bus.B        = tB[1];
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.out_valid !== 1'b0)
                leaks++;
            @(negedge clk);
        end
        vectors++;
        if (leaks != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_suppress got %0d valid cycles expected 0", leaks);
        end
        bus.A        = tA[2];
        bus.B        = tB[2];
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_latency1 got ov=%b expected 0", bus.out_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.S !== tS[2]) begin
            miscompares++;
            $display("[TB] FAIL midreset_first got S=%h ov=%b expected S=%h ov=1", bus.S, bus.out_valid, tS[2]);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.S !== tS[2]) begin
            miscompares++;
            $display("[TB] FAIL midreset_hold got S=%h ov=%b expected S=%h ov=0", bus.S, bus.out_valid, tS[2]);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.A        = 32'h0;
        bus.B        = 32'h0;
        test_reset();
        test_arith();
        test_specials();
        test_range();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
